register_unit_mp: RTL and testbench

//  Next-generation architectural register file for the RISC-V core: N read ports, one write port,
//  x0 hardwired to zero, optional write-to-read bypass, a hardware clear sequence after reset,
//  and a busy scoreboard that tracks in-flight writes to each rd. Sits in decode, ahead of the ALU.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/register_unit_mp.sv | 108 ++++++++++
 tb/tb_register_unit_mp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the architectural register file: the clear FSM
// state encoding, the hardwired-zero index and flat-bus port slicing.
package regfile_pkg;

  localparam int REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // LSB of port `port` inside a flat bus built from `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per architectural register marking an issued but
// not yet retired write, with per-read-port lookup and optional bypass masking.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              active,
  input  logic                              iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
  input  logic                              ret_valid,
  input  logic [ADDRESS_WIDTH-1:0]          ret_rd,
  input  logic                              flush,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ra,
  output logic [NUM_READ-1:0]               rd_busy
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Issue is applied last so it overrides both a retire and a flush in the
  // same cycle: the issuing instruction is the newest producer.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else if (ret_valid) begin
      busy_next[ret_rd] = 1'b0;
    end
    if (iss_valid) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (active) begin
      busy <= busy_next;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      logic [ADDRESS_WIDTH-1:0] a;
      a = ra[port_lsb(i, ADDRESS_WIDTH) +: ADDRESS_WIDTH];
      rd_busy[i] = active && busy[a] &&
                   !((BYPASS != 0) && ret_valid && (ret_rd == a));
    end
  end

endmodule

// File: rtl/register_unit_mp.sv
// Multi-port architectural register file: x0 hardwired to zero, optional
// write-to-read bypass, post-reset hardware clear sequence and busy scoreboard.
module register_unit_mp
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              ready,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic                              we,
  input  logic [ADDRESS_WIDTH-1:0]          wa,
  input  logic [DATA_WIDTH-1:0]             wd,
  input  logic                              iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
  input  logic                              flush
);

  localparam int                       DEPTH    = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(REG_ZERO);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  state_e                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] clr_idx, clr_idx_next;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] ra_a [NUM_READ];
  logic                     write_ok;

  assign ready    = (state == READY);
  assign write_ok = ready && we && (wa != ZERO_IDX);

  for (genvar g = 0; g < NUM_READ; g++) begin : g_ra
    assign ra_a[g] = ra[port_lsb(g, ADDRESS_WIDTH) +: ADDRESS_WIDTH];
  end

  // Clear walks x1..x(DEPTH-1); x0 is never stored, reads of it are forced to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= ADDRESS_WIDTH'(1);
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    if (state == CLEAR) begin
      clr_idx_next = clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) begin
        state_next = READY;
      end
    end
  end

  // NOTE: the storage array has no reset branch; the clear FSM zeroes it over
  // DEPTH-1 cycles so the array can still map onto RAM/regfile macros.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (write_ok) begin
        mem[wa] <= wd;
      end
    end
  end

  // NOTE: combinational blocks assign every output a default first, then use
  // blocking overrides; this keeps the read mux free of inferred latches.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (ready && (ra_a[i] != ZERO_IDX)) begin
        if ((BYPASS != 0) && write_ok && (wa == ra_a[i])) begin
          rd[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = wd;
        end else begin
          rd[port_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = mem[ra_a[i]];
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .BYPASS        (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .active    (ready),
    .iss_valid (iss_valid && (iss_rd != ZERO_IDX)),
    .iss_rd    (iss_rd),
    .ret_valid (write_ok),
    .ret_rd    (wa),
    .flush     (flush),
    .ra        (ra),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_register_unit_mp.sv
// Directed bench: a 3-port bypassing instance and a 2-port non-bypassing
// instance share stimulus; expected values are hand-derived constants.
module tb_register_unit_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] ra;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;

  logic        ready_bp, ready_nb;
  logic [95:0] rd_bp;
  logic [63:0] rd_nb;
  logic [2:0]  busy_bp;
  logic [1:0]  busy_nb;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  register_unit_mp #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(3), .BYPASS(1)) u_bp (
    .clk(clk), .rst(rst), .ready(ready_bp), .ra(ra), .rd(rd_bp), .rd_busy(busy_bp),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
  );

  register_unit_mp #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .ready(ready_nb), .ra(ra[9:0]), .rd(rd_nb), .rd_busy(busy_nb),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [4:0] a);
    ra[p*5 +: 5] = a;
  endtask

  function automatic logic [31:0] bp(input int p);
    return rd_bp[p*32 +: 32];
  endfunction

  function automatic logic [31:0] nb(input int p);
    return rd_nb[p*32 +: 32];
  endfunction

  initial begin
    rst = 1'b1; ra = '0; we = 1'b0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;

    // Reset, then restart the clear at cycle 10
    step();
    check("reset_ready_bp", 32'(ready_bp), 32'd0);
    check("reset_ready_nb", 32'(ready_nb), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("midclear_ready", 32'(ready_bp), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_ra(0, 5'd5);
    for (int c = 0; c < 31; c++) begin
      check($sformatf("clear_ready_c%0d", c), 32'(ready_bp), 32'd0);
      check($sformatf("clear_rd_c%0d", c), bp(0), 32'd0);
      step();
    end
    check("ready_after_31_bp", 32'(ready_bp), 32'd1);
    check("ready_after_31_nb", 32'(ready_nb), 32'd1);

    for (int r = 0; r < 32; r++) begin
      set_ra(0, 5'(r));
      #1;
      check($sformatf("zero_x%0d", r), bp(0), 32'd0);
      step();
    end

    // Write x5 with bypass / without bypass
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; set_ra(0, 5'd5);
    #1;
    check("bypass_x5_bp", bp(0), 32'hDEADBEEF);
    check("bypass_x5_nb", nb(0), 32'h0);
    step();
    we = 1'b0;
    #1;
    check("after_x5_bp", bp(0), 32'hDEADBEEF);
    check("after_x5_nb", nb(0), 32'hDEADBEEF);

    // Writes and issues to x0 are ignored
    we = 1'b1; wa = 5'd0; wd = 32'h1234; iss_valid = 1'b1; iss_rd = 5'd0; set_ra(0, 5'd0);
    #1;
    check("x0_same_cycle", bp(0), 32'h0);
    step();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("x0_next_cycle", bp(0), 32'h0);
    check("x0_busy", 32'(busy_bp[0]), 32'd0);

    // Scoreboard set, set-wins over retire, then retire
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0; set_ra(1, 5'd7);
    #1;
    check("busy_x7_bp", 32'(busy_bp[1]), 32'd1);
    check("busy_x7_nb", 32'(busy_nb[1]), 32'd1);
    we = 1'b1; wa = 5'd7; wd = 32'h77; iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    check("fwd_busy_x7_bp", 32'(busy_bp[1]), 32'd0);
    check("fwd_busy_x7_nb", 32'(busy_nb[1]), 32'd1);
    check("fwd_data_x7_bp", bp(1), 32'h77);
    check("fwd_data_x7_nb", nb(1), 32'h0);
    step();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("setwins_x7_bp", 32'(busy_bp[1]), 32'd1);
    check("setwins_x7_nb", 32'(busy_nb[1]), 32'd1);
    check("data_x7", nb(1), 32'h77);
    we = 1'b1; wa = 5'd7; wd = 32'h78;
    step();
    we = 1'b0;
    #1;
    check("retired_x7_bp", 32'(busy_bp[1]), 32'd0);
    check("retired_x7_nb", 32'(busy_nb[1]), 32'd0);
    check("data_x7_new", bp(1), 32'h78);

    // Flush with simultaneous issue
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_rd = 5'd9;
    step();
    iss_valid = 1'b0; set_ra(0, 5'd3); set_ra(1, 5'd9); set_ra(2, 5'd0);
    #1;
    check("busy_x3_pre", 32'(busy_bp[0]), 32'd1);
    check("busy_x9_pre", 32'(busy_nb[1]), 32'd1);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    flush = 1'b0; iss_valid = 1'b0;
    #1;
    check("flush_x3_bp", 32'(busy_bp[0]), 32'd0);
    check("flush_x9_bp", 32'(busy_bp[1]), 32'd1);
    check("flush_x3_nb", 32'(busy_nb[0]), 32'd0);
    check("flush_x9_nb", 32'(busy_nb[1]), 32'd1);

    // Three ports reading 1,2,1 while x1 is written
    we = 1'b1; wa = 5'd2; wd = 32'h22222222;
    step();
    wa = 5'd1; wd = 32'hCAFEF00D; set_ra(0, 5'd1); set_ra(1, 5'd2); set_ra(2, 5'd1);
    #1;
    check("p0_fwd", bp(0), 32'hCAFEF00D);
    check("p1_nofwd", bp(1), 32'h22222222);
    check("p2_fwd", bp(2), 32'hCAFEF00D);
    check("p0_nb_old", nb(0), 32'h0);
    step();
    we = 1'b0;
    #1;
    check("p2_x1_stored", bp(2), 32'hCAFEF00D);
    check("p0_nb_x1_stored", nb(0), 32'hCAFEF00D);

    // Top register and x4, then reset while READY clears everything
    we = 1'b1; wa = 5'd31; wd = 32'hFFFF0000;
    step();
    wa = 5'd4; wd = 32'h4444;
    step();
    we = 1'b0; set_ra(0, 5'd31); set_ra(1, 5'd4);
    #1;
    check("x31_stored", bp(0), 32'hFFFF0000);
    check("x4_stored", nb(1), 32'h4444);
    rst = 1'b1;
    step();
    rst = 1'b0;
    we = 1'b1; wa = 5'd4; wd = 32'hAAAA; iss_valid = 1'b1; iss_rd = 5'd4; set_ra(2, 5'd9);
    for (int c = 0; c < 31; c++) begin
      check($sformatf("reclear_ready_c%0d", c), 32'(ready_nb), 32'd0);
      check($sformatf("reclear_busy_c%0d", c), 32'(busy_bp[1]), 32'd0);
      step();
    end
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("reclear_ready", 32'(ready_bp), 32'd1);
    check("reclear_x31", bp(0), 32'h0);
    check("reclear_x4", nb(1), 32'h0);
    check("reclear_busy_x4", 32'(busy_bp[1]), 32'd0);
    check("reclear_busy_x9", 32'(busy_bp[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
